// File: rtl/led_seq_pkg.sv
// Shared types and constant pattern tables for the LED sequencer.
package led_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        MODE_FLASH  = 2'd0,
        MODE_FILL   = 2'd1,
        MODE_WALK   = 2'd2,
        MODE_MIRROR = 2'd3
    } mode_t;

    localparam logic [3:0] STEPS_FLASH  = 4'd4;
    localparam logic [3:0] STEPS_FILL   = 4'd9;
    localparam logic [3:0] STEPS_WALK   = 4'd8;
    localparam logic [3:0] STEPS_MIRROR = 4'd8;

    localparam logic [7:0] FLASH_TAB  [4] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    localparam logic [7:0] FILL_TAB   [9] = '{8'h00, 8'h80, 8'hC0, 8'hE0, 8'hF0,
                                              8'hF8, 8'hFC, 8'hFE, 8'hFF};
    localparam logic [7:0] WALK_TAB   [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                                              8'h10, 8'h20, 8'h40, 8'h80};
    localparam logic [7:0] MIRROR_TAB [8] = '{8'h81, 8'hC3, 8'hE7, 8'hFF,
                                              8'h18, 8'h3C, 8'h7E, 8'hFF};

    function automatic logic [3:0] last_step(input mode_t m);
        case (m)
            MODE_FLASH: return STEPS_FLASH - 4'd1;
            MODE_FILL:  return STEPS_FILL - 4'd1;
            MODE_WALK:  return STEPS_WALK - 4'd1;
            default:    return STEPS_MIRROR - 4'd1;
        endcase
    endfunction

    function automatic logic [7:0] pattern(input mode_t m, input logic [3:0] s);
        case (m)
            MODE_FLASH: return FLASH_TAB[s[1:0]];
            MODE_FILL:  return (s > 4'd8) ? 8'h00 : FILL_TAB[s];
            MODE_WALK:  return WALK_TAB[s[2:0]];
            default:    return MIRROR_TAB[s[2:0]];
        endcase
    endfunction

endpackage

// File: rtl/led_tick_div.sv
// Step-rate divider: tick is high on the enabled cycle that ends each TICK_DIV-cycle period.
module led_tick_div #(
    parameter int unsigned TICK_DIV = 8388608,
    parameter int unsigned CNT_W    = 24
) (
    input  logic mclk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == CNT_LAST);

    // NOTE: registers take non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: plays the table chosen by mode, one step per TICK_DIV mclk cycles.
// Define LED_SEQ_LOOP_EN to repeat the pattern forever instead of ending with a done pulse.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int unsigned TICK_DIV = 8388608,
    parameter int unsigned CNT_W    = 24
) (
    input  logic       mclk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic [1:0] mode,
    output logic [7:0] led,
    output logic       busy,
    output logic       done,
    output logic [3:0] step
);

    state_t     state, state_nxt;
    mode_t      mode_q, mode_nxt;
    logic [7:0] led_nxt;
    logic [3:0] step_nxt;
    logic       tick;
    logic       cnt_en;
    logic       div_rst_n;

    // Stop and pause outrank the tick, so the counter only advances on an uncontested RUN cycle.
    assign cnt_en    = (state == ST_RUN) && !stop && !pause;
    assign div_rst_n = rst_n && (state_nxt != ST_IDLE);

    led_tick_div #(
        .TICK_DIV(TICK_DIV),
        .CNT_W   (CNT_W)
    ) u_tick_div (
        .mclk (mclk),
        .rst_n(div_rst_n),
        .en   (cnt_en),
        .tick (tick)
    );

    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            mode_q <= MODE_FLASH;
            led    <= 8'h00;
            step   <= 4'd0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            mode_q <= mode_nxt;
            led    <= led_nxt;
            step   <= step_nxt;
            busy   <= (state_nxt == ST_RUN) || (state_nxt == ST_PAUSE);
            done   <= (state_nxt == ST_DONE);
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        mode_nxt  = mode_q;
        led_nxt   = led;
        step_nxt  = step;

        case (state)
            ST_IDLE: begin
                led_nxt  = 8'h00;
                step_nxt = 4'd0;
                if (start && !stop) begin
                    state_nxt = ST_RUN;
                    mode_nxt  = mode_t'(mode);
                    led_nxt   = pattern(mode_t'(mode), 4'd0);
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                    led_nxt   = 8'h00;
                    step_nxt  = 4'd0;
                end else if (pause) begin
                    state_nxt = ST_PAUSE;
                end else if (tick) begin
                    if (step == last_step(mode_q)) begin
`ifdef LED_SEQ_LOOP_EN
                        step_nxt = 4'd0;
                        led_nxt  = pattern(mode_q, 4'd0);
`else
                        state_nxt = ST_DONE;
`endif
                    end else begin
                        step_nxt = step + 4'd1;
                        led_nxt  = pattern(mode_q, step + 4'd1);
                    end
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                    led_nxt   = 8'h00;
                    step_nxt  = 4'd0;
                end else if (!pause) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                led_nxt   = 8'h00;
                step_nxt  = 4'd0;
            end
        endcase
    end

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 8388608 (2^23); mclk cycles per pattern step, legal range 2..2^24.
REQ-002 Parameter CNT_W, default 24; width of the tick counter, SHALL hold TICK_DIV-1.
REQ-003 mclk  input  1  system clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  begin a sequence; sampled only in IDLE.
REQ-006 stop  input  1  abort the sequence; return to IDLE.
REQ-007 pause  input  1  level; freeze the sequence while high.
REQ-008 mode  input  2  pattern select: 0 FLASH, 1 FILL, 2 WALK, 3 MIRROR; latched on start.
REQ-009 led  output  8  registered pattern output.
REQ-010 busy  output  1  high in RUN or PAUSE.
REQ-011 done  output  1  one-cycle pulse on normal sequence completion.
REQ-012 step  output  4  current step index.

Function
REQ-013 Pattern tables, indexed from step 0:
- FLASH (4 steps): FF,00,FF,00.
- FILL (9 steps): 00,80,C0,E0,F0,F8,FC,FE,FF.
- WALK (8 steps): 01,02,04,08,10,20,40,80.
- MIRROR (8 steps): 81,C3,E7,FF,18,3C,7E,FF.
REQ-014 FSM states: IDLE, RUN, PAUSE, DONE.
REQ-015 IDLE: led=00, step=0, busy=0, tick counter=0.
REQ-016 IDLE->RUN on start=1 and stop=0. Same edge: latch mode, step=0, led=table[mode][0], busy=1, so the new values are visible one cycle after the sampled edge.
REQ-017 The tick counter SHALL count only in RUN, over 0..TICK_DIV-1. The tick is the cycle with count==TICK_DIV-1, after which the counter wraps to 0.
REQ-018 On a tick in RUN at a non-last step: step+1 and led=table[mode][step+1] on the same edge.
- The first advance occurs exactly TICK_DIV cycles after RUN entry.
REQ-019 On a tick at the last step: behaviour per REQ-030/031.
REQ-020 RUN->PAUSE when pause=1. In PAUSE:
- the counter, step and led hold;
- PAUSE->RUN when pause=0;
- the count resumes from its held value.
REQ-021 Priority within RUN: stop > pause > tick. A tick coincident with pause is lost; the counter holds at TICK_DIV-1 and the tick fires on the first RUN cycle after resume.
REQ-022 stop=1 in RUN or PAUSE: next state IDLE with REQ-015 values; done stays 0.
REQ-023 start while busy SHALL be ignored. mode changes while busy SHALL be ignored.
REQ-024 DONE lasts exactly one cycle:
- done=1, busy=0, led holds the final pattern;
- then IDLE unconditionally;
- start during DONE is ignored.
REQ-025 start and stop both high in IDLE: stop wins, remain IDLE.

Reset
REQ-026 rst_n=0 at a rising mclk edge forces IDLE, led=00, step=0, busy=0, done=0, counter=0, latched mode=0.
REQ-027 Reset asserted mid-RUN or mid-PAUSE aborts without a done pulse.
REQ-028 start is honoured on the first edge with rst_n=1.
REQ-029 No output SHALL depend on rst_n combinationally.

Configuration
REQ-030 Macro LED_SEQ_LOOP_EN defined: a tick at the last step wraps to step 0 with led=table[mode][0]. Sequence repeats until stop or reset; DONE and done are never reached.
REQ-031 LED_SEQ_LOOP_EN undefined: a tick at the last step enters DONE (REQ-024).

Structure
REQ-032 Package led_seq_pkg SHALL hold:
- the FSM state enum;
- mode codes MODE_FLASH/FILL/WALK/MIRROR;
- per-mode step counts (4,9,8,8);
- the pattern tables as constants.
REQ-033 Sub-module led_tick_div SHALL hold the tick counter, with ports mclk, rst_n, en, tick. The counter holds when en=0 and clears when the FSM is IDLE.

Verification (TICK_DIV=4 in all benches)
REQ-034 Reset, then start=1 mode=2 for one cycle -> busy=1 and led=01 next cycle; led=02 four cycles later; led=80 at 28 cycles after start.
REQ-035 Loop disabled, mode=0:
- led FF,00,FF,00 at 4-cycle spacing;
- after the 4th step's tick, done=1 for one cycle with led=00 and busy=0;
- then IDLE.
REQ-036 mode=1 run, pause=1 for 10 cycles at step 3 (led=E0) -> led, step and count frozen; on release the remaining count completes, then led=F0.
REQ-037 stop=1 at step 5 of MIRROR (3C) -> next cycle led=00, busy=0, done=0. Separately, start and stop high together in IDLE -> stays IDLE.
REQ-038 LED_SEQ_LOOP_EN defined, mode=2 -> after 80 the next tick shows 01; done is never asserted over 3 passes.
REQ-039 rst_n=0 for one cycle mid-FILL -> all outputs reset per REQ-026 on that edge; no done pulse.
